// File: rtl/icache_direct.sv
// icache_direct: direct-mapped, one-word-per-block, read-only instruction cache.
// Hits are answered combinationally in IDLE; a miss runs a two-state refill FSM
// (IDLE/FILL) against the memory controller instruction port.
// Optional feature macro: ICACHE_STATS_EN adds hit_count / miss_count ports.
module icache_direct #(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        flush,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic {IDLE, FILL} state_t;

  state_t            state;
  logic [SETS-1:0]   valid;
  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [31:0]       data_mem [SETS];
  logic [31:0]       miss_addr;
  logic              iren_q;
  logic [31:0]       iaddr_q;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag_in;
  logic [IDX_W-1:0]  midx;
  logic [TAG_W-1:0]  mtag;
  logic              lookup_hit;
  logic              start_fill;
  logic              fill_done;
  logic              unused_addr_bits;

  assign idx    = imemaddr[IDX_W+1:2];
  assign tag_in = imemaddr[31:IDX_W+2];
  assign midx   = miss_addr[IDX_W+1:2];
  assign mtag   = miss_addr[31:IDX_W+2];
  // Byte offset is ignored: fetches are word aligned.
  assign unused_addr_bits = ^{imemaddr[1:0], miss_addr[1:0]};

  assign lookup_hit = valid[idx] && (tag_mem[idx] == tag_in);
  assign start_fill = (state == IDLE) && imemREN && !lookup_hit;
  assign fill_done  = (state == FILL) && !iwait;

  // Hit path: same-cycle answer, only while idle and requested.
  always_comb begin
    ihit     = (state == IDLE) && imemREN && lookup_hit;
    imemload = ihit ? data_mem[idx] : 32'h0;
  end

  assign iREN  = iren_q;
  assign iaddr = iaddr_q;

  // Refill FSM with registered memory-side outputs; flush clears valid last so it
  // overrides a block being validated on the same edge.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      valid     <= '0;
      miss_addr <= 32'h0;
      iren_q    <= 1'b0;
      iaddr_q   <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (start_fill) begin
            miss_addr <= {imemaddr[31:2], 2'b00};
            iaddr_q   <= {imemaddr[31:2], 2'b00};
            iren_q    <= 1'b1;
            state     <= FILL;
          end
        end
        FILL: begin
          if (!iwait) begin
            valid[midx] <= 1'b1;
            iren_q      <= 1'b0;
            iaddr_q     <= 32'h0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (flush) valid <= '0;
    end
  end

  // Tag/data arrays: written on refill completion, no reset needed.
  always_ff @(posedge CLK) begin
    if (fill_done) begin
      tag_mem[midx]  <= mtag;
      data_mem[midx] <= iload;
    end
  end

`ifdef ICACHE_STATS_EN
  // Statistics: hits per ihit cycle, misses per refill start; wrap naturally.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count  <= 32'h0;
      miss_count <= 32'h0;
    end else begin
      if (ihit)       hit_count  <= hit_count + 32'd1;
      if (start_fill) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule
